// File: rtl/if_id_skid_pkg.sv
// Shared IF/ID pipeline definitions: occupancy encoding, default NOP and counter width.
// Used by if_id_skid and its optional if_id_perf counters.
package if_id_skid_pkg;

    // Encoding equals the number of held entries; the perf counters rely on this.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } occ_state_e;

    localparam int unsigned CNT_W            = 32;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_perf.sv
// IF/ID performance counters: decode stall cycles and entries discarded by flush.
// Only instantiated when IF_ID_PERF_CNT_EN is defined.
module if_id_perf
    import if_id_skid_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [1:0]       held_cnt_i,
    input  logic             push_drop_i,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_drops_o
);

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] drops_q, drops_d;

    always_comb begin
        stall_d = stall_q;
        drops_d = drops_q;
        if (stall_i) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (flush_i) begin
            drops_d = drops_q + CNT_W'(held_cnt_i) + CNT_W'(push_drop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            drops_q <= '0;
        end else begin
            stall_q <= stall_d;
            drops_q <= drops_d;
        end
    end

    assign stall_cycles_o = stall_q;
    assign flush_drops_o  = drops_q;

endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a two-entry skid buffer and single-cycle flush.
// Define IF_ID_PERF_CNT_EN to add the stall/flush-drop counters.
module if_id_skid
    import if_id_skid_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid_i,
    output logic              if_ready_o,
    input  logic [ADDR_W-1:0] if_pc_i,
    input  logic [INST_W-1:0] if_inst_i,
    input  logic              flush_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [ADDR_W-1:0] id_pc_o,
`ifdef IF_ID_PERF_CNT_EN
    output logic [CNT_W-1:0]  stall_cycles_o,
    output logic [CNT_W-1:0]  flush_drops_o,
`endif
    output logic [INST_W-1:0] id_inst_o
);

    occ_state_e        state_q, state_d;
    logic [ADDR_W-1:0] head_pc_q, head_pc_d;
    logic [INST_W-1:0] head_inst_q, head_inst_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;
    logic              push, pop;

    assign push = if_valid_i & if_ready_o;
    assign pop  = id_valid_o & id_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) state_d = StOne;
                end
                StOne: begin
                    if (push && !pop) begin
                        state_d = StTwo;
                    end else if (pop && !push) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (pop) state_d = StOne;
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // Both handshake outputs decode the state flop only, so no input reaches an output.
    always_comb begin
        if_ready_o = (state_q != StTwo);
        id_valid_o = (state_q != StEmpty);
    end

    always_comb begin
        head_pc_d   = head_pc_q;
        head_inst_d = head_inst_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        if (flush_i) begin
            head_inst_d = NOP_INST;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        head_pc_d   = if_pc_i;
                        head_inst_d = if_inst_i;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        head_pc_d   = if_pc_i;
                        head_inst_d = if_inst_i;
                    end else if (push) begin
                        skid_pc_d   = if_pc_i;
                        skid_inst_d = if_inst_i;
                    end else if (pop) begin
                        head_inst_d = NOP_INST;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        head_pc_d   = skid_pc_q;
                        head_inst_d = skid_inst_q;
                    end
                end
                default: head_inst_d = NOP_INST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_pc_q   <= '0;
            head_inst_q <= NOP_INST;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
        end else begin
            head_pc_q   <= head_pc_d;
            head_inst_q <= head_inst_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
        end
    end

    assign id_pc_o   = head_pc_q;
    assign id_inst_o = head_inst_q;

`ifdef IF_ID_PERF_CNT_EN
    if_id_perf u_perf (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (id_valid_o & ~id_ready_i),
        .flush_i        (flush_i),
        .held_cnt_i     (state_q),
        .push_drop_i    (push & flush_i),
        .stall_cycles_o (stall_cycles_o),
        .flush_drops_o  (flush_drops_o)
    );
`else
    // Counters absent; datapath is unchanged.
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// Scoreboard bench for if_id_skid: stimulus queues expected entries, a monitor pops
// and compares every entry decode consumes.
module tb_if_id_skid;

    localparam logic [31:0] TB_NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid_i = 1'b0;
    logic        if_ready_o;
    logic [31:0] if_pc_i = '0;
    logic [31:0] if_inst_i = '0;
    logic        flush_i = 1'b0;
    logic        id_valid_o;
    logic        id_ready_i = 1'b0;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cycles_o;
    logic [31:0] flush_drops_o;
`endif

    int   n_chk  = 0;
    int   n_fail = 0;
    int   m_cnt  = 0;
    ent_t exp_q[$];

    always #5 clk = ~clk;

    if_id_skid #(
        .ADDR_W   (32),
        .INST_W   (32),
        .NOP_INST (TB_NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid_i     (if_valid_i),
        .if_ready_o     (if_ready_o),
        .if_pc_i        (if_pc_i),
        .if_inst_i      (if_inst_i),
        .flush_i        (flush_i),
        .id_valid_o     (id_valid_o),
        .id_ready_i     (id_ready_i),
        .id_pc_o        (id_pc_o),
`ifdef IF_ID_PERF_CNT_EN
        .stall_cycles_o (stall_cycles_o),
        .flush_drops_o  (flush_drops_o),
`endif
        .id_inst_o      (id_inst_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every entry decode consumes must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && id_valid_o === 1'b1 && id_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out: got pc=%0h required no entry (t=%0t)",
                         id_pc_o, $time);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("out_pc", 64'(id_pc_o), 64'(e.pc));
                chk("out_inst", 64'(id_inst_o), 64'(e.inst));
            end
        end
    end

    // One clock of stimulus; handshake checks against the occupancy model, then model update.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl);
        logic push, pop;
        if_valid_i = v;
        if_pc_i    = pc;
        if_inst_i  = inst;
        id_ready_i = rdy;
        flush_i    = fl;
        @(negedge clk);
        chk("if_ready", 64'(if_ready_o), 64'(m_cnt != 2));
        chk("id_valid", 64'(id_valid_o), 64'(m_cnt != 0));
        if (m_cnt == 0) chk("idle_inst_nop", 64'(id_inst_o), 64'(TB_NOP));
        #1;
        push = v && (m_cnt != 2);
        pop  = rdy && (m_cnt != 0);
        if (fl) begin
            exp_q.delete();
            m_cnt = 0;
        end else begin
            if (push) exp_q.push_back('{pc, inst});
            m_cnt = m_cnt + int'(push) - int'(pop);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst        = 1'b1;
        if_valid_i = 1'b1;
        if_pc_i    = 32'h0000_DEAD;
        if_inst_i  = 32'hDEAD_BEEF;
        id_ready_i = 1'b0;
        flush_i    = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_cnt = 0;
    endtask

    initial begin
        // Reset and idle
        do_reset(2);
        if_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_id_valid", 64'(id_valid_o), 64'(0));
        chk("rst_id_inst", 64'(id_inst_o), 64'(TB_NOP));
        chk("rst_id_pc", 64'(id_pc_o), 64'(0));
        chk("rst_if_ready", 64'(if_ready_o), 64'(1));
        @(posedge clk);
        #1;

        // Streaming
        cyc(1'b1, 32'h100, 32'h2401_0100, 1'b1, 1'b0);
        cyc(1'b1, 32'h104, 32'h2401_0104, 1'b1, 1'b0);
        cyc(1'b1, 32'h108, 32'h2401_0108, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Stall absorb: 0x208 is refused while full, then accepted after recovery
        cyc(1'b1, 32'h200, 32'h2401_0200, 1'b0, 1'b0);
        cyc(1'b1, 32'h204, 32'h2401_0204, 1'b0, 1'b0);
        cyc(1'b1, 32'h208, 32'h2401_0208, 1'b0, 1'b0);
        cyc(1'b1, 32'h208, 32'h2401_0208, 1'b1, 1'b0);
        cyc(1'b1, 32'h208, 32'h2401_0208, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush in TWO with a simultaneous fetch
        cyc(1'b1, 32'h280, 32'h2401_0280, 1'b0, 1'b0);
        cyc(1'b1, 32'h284, 32'h2401_0284, 1'b0, 1'b0);
        cyc(1'b1, 32'h288, 32'h2401_0288, 1'b0, 1'b1);
        chk("flush_keeps_pc", 64'(id_pc_o), 64'(32'h280));
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h300, 32'h2401_0300, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with pop in ONE
        cyc(1'b1, 32'h400, 32'h2401_0400, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Reset while holding an entry
        cyc(1'b1, 32'h600, 32'h2401_0600, 1'b0, 1'b0);
        do_reset(1);
        if_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_pc", 64'(id_pc_o), 64'(0));
        @(posedge clk);
        #1;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

`ifdef IF_ID_PERF_CNT_EN
        // Five stall cycles, then flush while holding two entries
        do_reset(1);
        cyc(1'b1, 32'h500, 32'h2401_0500, 1'b0, 1'b0);
        cyc(1'b1, 32'h504, 32'h2401_0504, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        chk("perf_stall_cycles", 64'(stall_cycles_o), 64'(5));
        chk("perf_flush_drops", 64'(flush_drops_o), 64'(2));
`endif

        chk("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
